// File: rtl/dvp_pattern_tx.sv
`timescale 1ns/1ps
// dvp_pattern_tx: synthetic DVP camera transmitter producing an 8-bit RGB565
// byte stream (vsync/href/pdata) with programmable active size and blanking.
// Optional build macro DVP_TX_FRAME_CNT_EN: adds o_frame_cnt and stamps the
// running frame count into pixel (0,0) of every frame.
//
// state  | meaning
// IDLE   | outputs low, waiting for i_enable
// VSYNC  | o_vsync high for V_SYNC lines
// VBP    | back porch, V_BP lines, outputs low
// ACTIVE | V_ACTIVE lines: 2*H_ACTIVE href bytes then H_BLANK blank cycles
// VFP    | front porch, V_FP lines; o_frame_done on the final cycle
module dvp_pattern_tx #(
  parameter int H_ACTIVE = 1280,
  parameter int H_BLANK  = 370,
  parameter int V_ACTIVE = 720,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int V_FP     = 5
) (
  input  logic        i_pclk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic [1:0]  i_pattern,
  input  logic [15:0] i_solid_rgb565,
  output logic        o_vsync,
  output logic        o_href,
  output logic [7:0]  o_pdata,
`ifdef DVP_TX_FRAME_CNT_EN
  output logic [15:0] o_frame_cnt,
`endif
  output logic        o_frame_done
);

  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int BAR_CYC  = 2 * (H_ACTIVE / 8);
  localparam int LN_MAX_A = (V_SYNC > V_ACTIVE) ? V_SYNC : V_ACTIVE;
  localparam int LN_MAX_B = (V_BP > V_FP) ? V_BP : V_FP;
  localparam int LN_MAX   = (LN_MAX_A > LN_MAX_B) ? LN_MAX_A : LN_MAX_B;
  localparam int CYC_W    = $clog2(LINE_LEN);
  localparam int LN_W     = (LN_MAX > 1) ? $clog2(LN_MAX) : 1;
  localparam int X_W      = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int Y_W      = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int BL_W     = (BAR_CYC > 1) ? $clog2(BAR_CYC) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(LINE_LEN - 1);
  localparam logic [CYC_W-1:0] CYC_HB   = CYC_W'(H_BLANK);
  localparam logic [BL_W-1:0]  BAR_LAST = BL_W'(BAR_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFP    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;          // cycles left in current line
  logic [LN_W-1:0]   line_q, line_d;        // lines left in current phase
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic              phase_q, phase_d;      // 0 = high byte, 1 = low byte
  logic [2:0]        bar_q, bar_d;
  logic [BL_W-1:0]   bar_left_q, bar_left_d; // cycles left in current bar
  logic [1:0]        pat_q, pat_d;
  logic [15:0]       solid_q, solid_d;
  logic              vsync_q, vsync_d;
  logic              href_q, href_d;
  logic [7:0]        pdata_q, pdata_d;
  logic              done_q, done_d;

  logic              line_end, phase_end;
  logic              start_frame, enter_active;
  logic [15:0]       x_ext, y_ext, pixel;

  assign line_end  = (cyc_q == '0);
  assign phase_end = line_end && (line_q == '0);

  // frame sequencing: line/phase down-counters and pixel coordinate counters
  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    line_d       = line_q;
    x_d          = x_q;
    y_d          = y_q;
    phase_d      = phase_q;
    bar_d        = bar_q;
    bar_left_d   = bar_left_q;
    pat_d        = pat_q;
    solid_d      = solid_q;
    start_frame  = 1'b0;
    enter_active = 1'b0;

    if (state_q != ST_IDLE) begin
      if (!line_end) begin
        cyc_d = cyc_q - 1'b1;
      end else if (line_q != '0) begin
        cyc_d  = CYC_LAST;
        line_d = line_q - 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: start_frame = i_enable;
      ST_VSYNC: begin
        if (phase_end) begin
          if (V_BP > 0) begin
            state_d = ST_VBP;
            cyc_d   = CYC_LAST;
            line_d  = LN_W'(V_BP - 1);
          end else begin
            enter_active = 1'b1;
          end
        end
      end
      ST_VBP: enter_active = phase_end;
      ST_ACTIVE: begin
        if (phase_end) begin
          state_d = ST_VFP;
          cyc_d   = CYC_LAST;
          line_d  = LN_W'(V_FP - 1);
        end else if (line_end) begin
          x_d        = '0;
          phase_d    = 1'b0;
          bar_d      = '0;
          bar_left_d = BAR_LAST;
          y_d        = y_q + 1'b1;
        end else if (cyc_q > CYC_HB) begin
          // only step while the next cycle is still an href byte, so the
          // coordinates never run past the last pixel of the line
          phase_d = ~phase_q;
          if (phase_q) x_d = x_q + 1'b1;
          if (bar_left_q == '0) begin
            bar_d      = bar_q + 3'd1;
            bar_left_d = BAR_LAST;
          end else begin
            bar_left_d = bar_left_q - 1'b1;
          end
        end
      end
      ST_VFP: begin
        if (phase_end) begin
          if (i_enable) start_frame = 1'b1;
          else          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_frame) begin
      state_d    = ST_VSYNC;
      cyc_d      = CYC_LAST;
      line_d     = LN_W'(V_SYNC - 1);
      pat_d      = i_pattern;
      solid_d    = i_solid_rgb565;
    end

    if (start_frame || enter_active) begin
      x_d        = '0;
      y_d        = '0;
      phase_d    = 1'b0;
      bar_d      = '0;
      bar_left_d = BAR_LAST;
    end

    if (enter_active) begin
      state_d = ST_ACTIVE;
      cyc_d   = CYC_LAST;
      line_d  = LN_W'(V_ACTIVE - 1);
    end
  end

`ifdef DVP_TX_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // completed-frame counter, wraps naturally at 16 bits
  always_comb frame_cnt_d = frame_cnt_q + {15'd0, done_q};

  // frame counter register
  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end

  assign o_frame_cnt = frame_cnt_q;
`endif

  assign x_ext = 16'(x_d);
  assign y_ext = 16'(y_d);

  // outputs for the upcoming cycle, derived from the next state so they register cleanly
  always_comb begin
    vsync_d = (state_d == ST_VSYNC);
    href_d  = (state_d == ST_ACTIVE) && (cyc_d >= CYC_HB);
    done_d  = (state_d == ST_VFP) && (cyc_d == '0) && (line_d == '0);
    pixel   = 16'h0000;
    case (pat_d)
      2'd0: begin
        case (bar_d)
          3'd0: pixel = 16'hFFFF;
          3'd1: pixel = 16'hFFE0;
          3'd2: pixel = 16'h07FF;
          3'd3: pixel = 16'h07E0;
          3'd4: pixel = 16'hF81F;
          3'd5: pixel = 16'hF800;
          3'd6: pixel = 16'h001F;
          3'd7: pixel = 16'h0000;
        endcase
      end
      2'd1:    pixel = x_ext + y_ext;
      2'd2:    pixel = solid_d;
      default: pixel = (x_ext[3] ^ y_ext[3]) ? 16'hFFFF : 16'h0000;
    endcase
`ifdef DVP_TX_FRAME_CNT_EN
    if (x_d == '0 && y_d == '0) pixel = frame_cnt_q;
`endif
    pdata_d = href_d ? (phase_d ? pixel[7:0] : pixel[15:8]) : 8'h00;
  end

  // state, counters and registered outputs
  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cyc_q      <= '0;
      line_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      phase_q    <= 1'b0;
      bar_q      <= '0;
      bar_left_q <= '0;
      pat_q      <= '0;
      solid_q    <= '0;
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      pdata_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      line_q     <= line_d;
      x_q        <= x_d;
      y_q        <= y_d;
      phase_q    <= phase_d;
      bar_q      <= bar_d;
      bar_left_q <= bar_left_d;
      pat_q      <= pat_d;
      solid_q    <= solid_d;
      vsync_q    <= vsync_d;
      href_q     <= href_d;
      pdata_q    <= pdata_d;
      done_q     <= done_d;
    end
  end

  assign o_vsync      = vsync_q;
  assign o_href       = href_q;
  assign o_pdata      = pdata_q;
  assign o_frame_done = done_q;

endmodule

// File: doc/dvp_pattern_tx.md
Name: dvp_pattern_tx

Overview:
- Synthetic DVP camera-sensor transmitter. Drives the same 8-bit RGB565 byte stream (vsync/href/pdata) that the camera front-end receives from the OV5642.
- Used for sensor-less bring-up of the capture → FIFO → HDMI path, and as the stimulus source in block/system benches.
- Generates complete frames with programmable active size and blanking, in one of four test patterns.

Parameters:
- H_ACTIVE, 1280, active pixels per line; must be a multiple of 8.
- H_BLANK, 370, horizontal blanking in i_pclk cycles (href low); ≥ 1.
- V_ACTIVE, 720, active lines per frame.
- V_SYNC, 5, lines with vsync high; ≥ 1.
- V_BP, 20, back-porch lines after vsync; ≥ 0.
- V_FP, 5, front-porch lines after the last active line; ≥ 1.

Ports:
- i_pclk  in  1  byte clock; all logic is on its rising edge.
- i_rst  in  1  reset.
- i_enable  in  1  1 = generate frames.
- i_pattern  in  2  0 = colour bars, 1 = ramp, 2 = solid, 3 = checkerboard.
- i_solid_rgb565  in  16  colour used for pattern 2.
- o_vsync  out  1  frame sync, active high, precedes active lines.
- o_href  out  1  high during active bytes.
- o_pdata  out  8  byte data: {R[4:0],G[5:3]} first, then {G[2:0],B[4:0]}.
- o_frame_done  out  1  one-cycle pulse on the last cycle of front porch.

Behaviour:
- Reset: i_rst, asynchronous, active-high; clock i_pclk.
- Reset values: all outputs 0, state IDLE, all counters 0.
- All outputs are registered. o_pdata = 0x00 whenever o_href = 0.
- Line period L = 2*H_ACTIVE + H_BLANK cycles. Every vertical phase is counted in whole lines of L cycles.
- States: IDLE → VSYNC → VBP → ACTIVE → VFP → (VSYNC | IDLE).
- IDLE:
  - Outputs low.
  - When i_enable = 1 is sampled, o_vsync = 1 on the next edge; enter VSYNC.
  - i_pattern and i_solid_rgb565 are latched on this same edge.
- VSYNC: o_vsync high for exactly V_SYNC*L cycles.
- VBP: V_BP*L cycles, all outputs low. If V_BP = 0, go straight to ACTIVE.
- ACTIVE, per line:
  - o_href high for 2*H_ACTIVE consecutive cycles, then low for H_BLANK cycles. There are exactly V_ACTIVE lines.
  - Each pixel takes two cycles: high byte pixel[15:8], then low byte pixel[7:0].
  - x (0..H_ACTIVE-1) and y (0..V_ACTIVE-1) are the pixel and line counters.
- VFP: V_FP*L cycles, outputs low. o_frame_done = 1 on the final cycle.
  - Next state is VSYNC if i_enable = 1 on that cycle (pattern relatched), else IDLE.
- Back-to-back frames have no idle gap: o_vsync rises on the cycle after o_frame_done.
- i_enable dropping mid-frame: the current frame completes unchanged, then IDLE.
- i_pattern or i_solid_rgb565 changing mid-frame: no effect until the next frame start.
- Pattern 0 (colour bars):
  - Bar width BW = H_ACTIVE/8; bar index b = x / BW, via a bar counter, no divider.
  - Colours by b: 0xFFFF white, 0xFFE0 yellow, 0x07FF cyan, 0x07E0 green, 0xF81F magenta, 0xF800 red, 0x001F blue, 0x0000 black.
- Pattern 1 (ramp): pixel = x[15:0] + y[15:0], modulo 2^16.
- Pattern 2 (solid): pixel = latched i_solid_rgb565.
- Pattern 3 (checkerboard): pixel = 0xFFFF if (x[3] XOR y[3]), else 0x0000 (8×8 squares).
- Counter widths: sized with $clog2 of each maximum. No wrap inside a frame; all counters clear at frame start.
- Reset asserted mid-frame: outputs drop to 0 immediately. After release, the block restarts from IDLE; no partial frame resumes.

Optional Feature:
- Macro: DVP_TX_FRAME_CNT_EN.
- Defined:
  - Adds output o_frame_cnt[15:0]: reset 0, increments on each o_frame_done, wraps 0xFFFF → 0.
  - The first pixel (x = 0, y = 0) of every frame carries o_frame_cnt instead of the pattern value, so the receiver can detect dropped frames.
- Undefined: the port is absent and pixel (0,0) follows the pattern.

Test Plan:
All scenarios use H_ACTIVE=8, H_BLANK=4, V_ACTIVE=4, V_SYNC=1, V_BP=1, V_FP=1, giving L = 20 and 140 cycles per frame.
- Timing: reset, then i_enable = 1 → o_vsync high 20 cycles; 20 low cycles; 4 lines of 16 href-high cycles each, href low 4 cycles between lines; o_frame_done after 140 cycles; next vsync rises the following cycle.
- Colour bars: line 0 bytes = FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00; identical on lines 1–3; o_pdata = 00 whenever href = 0.
- Solid/ramp: pattern 2 with 0x1234 → 12 34 repeated 8× per line; pattern 1, line 2 → pixels 0x0002..0x0009.
- Mid-frame change: switch i_pattern 0→3 and drop i_enable during line 1 → frame finishes as colour bars, o_frame_done pulses, outputs stay 0 in IDLE.
- Async reset pulse during ACTIVE → o_href/o_vsync/o_pdata go 0 without a clock edge; after release, a full 140-cycle frame is produced.
- With DVP_TX_FRAME_CNT_EN: 3 frames → first pixel bytes 00 00, 00 01, 00 02; o_frame_cnt = 3 after the third o_frame_done.
